// File: rtl/mem_arbiter_n.sv
// N-channel arbiter onto a single 8-bit external RAM bus: serialises 1/2/4/DATA_W-byte
// little-endian transfers with fixed-priority or round-robin grant, stall and read abort.
module mem_arbiter_n #(
  parameter int unsigned NCH    = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RR     = 0
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic [NCH-1:0]          req_i,
  input  logic [NCH-1:0]          we_i,
  input  logic [2*NCH-1:0]        size_i,
  input  logic [ADDR_W*NCH-1:0]   addr_i,
  input  logic [DATA_W*NCH-1:0]   wdata_i,
  input  logic [NCH-1:0]          abort_i,
  output logic [NCH-1:0]          grant_o,
  output logic [NCH-1:0]          done_o,
  output logic [DATA_W-1:0]       rdata_o,
  output logic                    busy_o,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [ADDR_W-1:0]       mem_a,
  output logic                    mem_wr
);

  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned IW = $clog2(NB) + 1;
  localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     ch_q, ptr_q, win, ptr_next;
  logic              we_q;
  logic [ADDR_W-1:0] base_q;
  logic [DATA_W-1:0] wdata_q, buf_q, rdata_q, merged;
  logic [IW-1:0]     n_q, idx_q, pend_idx_q;
  logic              pend_q;
  logic              win_found, start, abort_hit;

  logic [ADDR_W-1:0] addr_a  [NCH];
  logic [DATA_W-1:0] wdata_a [NCH];
  logic [1:0]        size_a  [NCH];

  function automatic logic [IW-1:0] nbytes(input logic [1:0] s);
    int unsigned v;
    v = (s == 2'd3) ? NB : (32'd1 << s);
    if (v > NB) v = NB;
    return IW'(v);
  endfunction

  always_comb begin
    for (int unsigned c = 0; c < NCH; c++) begin
      addr_a[c]  = addr_i[c*ADDR_W +: ADDR_W];
      wdata_a[c] = wdata_i[c*DATA_W +: DATA_W];
      size_a[c]  = size_i[c*2 +: 2];
    end
  end

  // Round-robin scans upward from ptr_q with wrap; fixed priority scans from 0.
  always_comb begin
    int unsigned cand;
    win_found = 1'b0;
    win       = '0;
    cand      = 0;
    for (int unsigned k = 0; k < NCH; k++) begin
      cand = (RR != 0) ? ((32'(ptr_q) + k) % NCH) : k;
      if (!win_found && req_i[cand[CW-1:0]]) begin
        win_found = 1'b1;
        win       = cand[CW-1:0];
      end
    end
    ptr_next = (32'(win) + 1 == NCH) ? '0 : win + 1'b1;
  end

  assign start     = rdy_in && win_found;
  assign abort_hit = (state_q != IDLE) && abort_i[ch_q] && !we_q;
  assign merged    = buf_q | (DATA_W'(mem_din) << (8 * pend_idx_q));

  always_comb begin
    state_d  = state_q;
    grant_o  = '0;
    done_o   = '0;
    busy_o   = (state_q != IDLE);
    mem_a    = '0;
    mem_wr   = 1'b0;
    mem_dout = '0;
    rdata_o  = rdata_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = XFER;
      end
      XFER: begin
        grant_o[ch_q] = 1'b1;
        mem_a         = base_q + ADDR_W'(idx_q);
        mem_wr        = we_q && rdy_in;
        if (we_q) mem_dout = wdata_q[8*idx_q +: 8];
        if (abort_hit)                                state_d = IDLE;
        else if (rdy_in && (idx_q == n_q - 1'b1))     state_d = DRAIN;
      end
      DRAIN: begin
        grant_o[ch_q] = 1'b1;
        state_d       = IDLE;
        if (!abort_hit) done_o[ch_q] = 1'b1;
        // Last read byte arrives this cycle, so present it combinationally with done_o.
        if (!we_q && !abort_hit) rdata_o = merged;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      ptr_q      <= '0;
      we_q       <= 1'b0;
      base_q     <= '0;
      wdata_q    <= '0;
      n_q        <= '0;
      idx_q      <= '0;
      pend_q     <= 1'b0;
      pend_idx_q <= '0;
      buf_q      <= '0;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= 1'b0;
      if (pend_q) buf_q <= merged;
      case (state_q)
        IDLE: begin
          if (start) begin
            ch_q    <= win;
            we_q    <= we_i[win];
            base_q  <= addr_a[win];
            wdata_q <= wdata_a[win];
            n_q     <= nbytes(size_a[win]);
            idx_q   <= '0;
            buf_q   <= '0;
            if (RR != 0) ptr_q <= ptr_next;
          end
        end
        XFER: begin
          if (!abort_hit && rdy_in) begin
            idx_q      <= idx_q + 1'b1;
            pend_q     <= !we_q;
            pend_idx_q <= idx_q;
          end
        end
        DRAIN: begin
          if (!we_q && !abort_hit) rdata_q <= merged;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Bench for mem_arbiter_n: transaction-level reference model with a byte-addressed RAM,
// directed scenarios with literal expectations, then randomized requests, stalls and aborts.
module tb_mem_arbiter_n;
  localparam int unsigned NCH = 2;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;

  logic clk = 1'b0;
  logic rst, rdy;
  logic [NCH-1:0]    req, we, abort;
  logic [2*NCH-1:0]  size;
  logic [AW*NCH-1:0] addr;
  logic [DW*NCH-1:0] wdata;
  logic [NCH-1:0]    grant, done, grant_rr, done_rr;
  logic [DW-1:0]     rdata, rdata_rr;
  logic              busy, busy_rr, mem_wr, mem_wr_rr;
  logic [7:0]        mem_din = 8'h00;
  logic [7:0]        mem_dout, mem_dout_rr;
  logic [AW-1:0]     mem_a, mem_a_rr;

  int checks = 0;
  int errors = 0;
  bit run_model = 1'b0;

  logic [7:0] ram  [logic [31:0]];
  logic [7:0] gold [logic [31:0]];

  always #5 clk = ~clk;

  mem_arbiter_n #(.NCH(NCH), .ADDR_W(AW), .DATA_W(DW), .RR(0)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .req_i(req), .we_i(we), .size_i(size),
    .addr_i(addr), .wdata_i(wdata), .abort_i(abort), .grant_o(grant), .done_o(done),
    .rdata_o(rdata), .busy_o(busy), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr));

  mem_arbiter_n #(.NCH(NCH), .ADDR_W(AW), .DATA_W(DW), .RR(1)) dut_rr (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .req_i(req), .we_i(we), .size_i(size),
    .addr_i(addr), .wdata_i(wdata), .abort_i(abort), .grant_o(grant_rr), .done_o(done_rr),
    .rdata_o(rdata_rr), .busy_o(busy_rr), .mem_din(mem_din), .mem_dout(mem_dout_rr),
    .mem_a(mem_a_rr), .mem_wr(mem_wr_rr));

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h3C;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : dflt(a);
  endfunction

  function automatic logic [7:0] gold_rd(input logic [31:0] a);
    return gold.exists(a) ? gold[a] : dflt(a);
  endfunction

  function automatic int unsigned nb(input logic [1:0] s);
    case (s)
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return (DW/8 < 4) ? DW/8 : 4;
      default: return DW/8;
    endcase
  endfunction

  function automatic logic [DW-1:0] exp_read(input logic [31:0] b, input int unsigned n);
    logic [DW-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < n; i++) v[8*i +: 8] = gold_rd(b + i);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // RAM: data for the address of cycle t appears in cycle t+1.
  always @(posedge clk) mem_din <= ram_rd(mem_a);
  always @(negedge clk) if (mem_wr) ram[mem_a] = mem_dout;

  // Reference model: transaction phase 0=idle 1=moving bytes 2=completion cycle.
  int unsigned     m_st = 0, m_ch = 0, m_n = 0, m_k = 0;
  logic            m_we = 1'b0;
  logic [31:0]     m_base = '0, m_wdata = '0;
  logic [DW-1:0]   m_rdata = '0;
  logic [NCH-1:0]  e_grant, e_done;
  logic [31:0]     e_a;
  logic [7:0]      e_dout;
  logic [DW-1:0]   e_rdata;
  logic            e_wr, hit;

  always @(negedge clk) begin
    if (run_model) begin
      hit     = (m_st != 0) && abort[m_ch] && !m_we;
      e_grant = '0; e_done = '0; e_a = '0; e_wr = 1'b0; e_dout = '0; e_rdata = m_rdata;
      if (m_st == 1) begin
        e_grant[m_ch] = 1'b1;
        e_a           = m_base + m_k;
        e_wr          = m_we && rdy;
        e_dout        = m_wdata[8*m_k +: 8];
      end else if (m_st == 2) begin
        e_grant[m_ch] = 1'b1;
        if (!hit) e_done[m_ch] = 1'b1;
        if (!m_we && !hit) e_rdata = exp_read(m_base, m_n);
      end
      chk("grant", grant, e_grant);
      chk("done", done, e_done);
      chk("busy", busy, m_st != 0);
      chk("mem_wr", mem_wr, e_wr);
      chk("rdata", rdata, e_rdata);
      if (m_st != 2) chk("mem_a", mem_a, e_a);
      if (m_st == 0 || e_wr) chk("mem_dout", mem_dout, e_dout);
      if (e_wr) gold[e_a] = e_dout;
      if (rst) begin
        m_st = 0; m_rdata = '0;
      end else begin
        case (m_st)
          0: if (rdy && req != '0) begin
               int w;
               w = 0;
               for (int k = NCH - 1; k >= 0; k--) if (req[k]) w = k;
               m_ch = w; m_we = we[w]; m_base = addr[32*w +: 32];
               m_wdata = wdata[32*w +: 32]; m_n = nb(size[2*w +: 2]); m_k = 0; m_st = 1;
             end
          1: if (hit) m_st = 0;
             else if (rdy) begin
               m_k++;
               if (m_k == m_n) m_st = 2;
             end
          default: begin
            if (!m_we && !hit) m_rdata = e_rdata;
            m_st = 0;
          end
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_ch(input int c, input logic w, input logic [1:0] s,
                        input logic [31:0] a, input logic [31:0] d);
    we[c] = w; size[2*c +: 2] = s; addr[32*c +: 32] = a; wdata[32*c +: 32] = d; req[c] = 1'b1;
  endtask

  task automatic wait_idle();
    int unsigned t;
    tick();
    req = '0; abort = '0; rdy = 1'b1; t = 0;
    @(negedge clk);
    while ((busy || busy_rr) && t < 40) begin @(negedge clk); t++; end
    chk("idle_timeout", busy | busy_rr, 0);
    tick();
  endtask

  logic [7:0]     wb [4];
  logic [NCH-1:0] sd, sg;
  logic [31:0]    r, a;

  initial begin
    req = '0; we = '0; size = '0; addr = '0; wdata = '0; abort = '0; rdy = 1'b0; rst = 1'b1;
    wb = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
    ram[32'h200] = 8'h11; ram[32'h201] = 8'h22; ram[32'h202] = 8'h33; ram[32'h203] = 8'h44;
    gold[32'h200] = 8'h11; gold[32'h201] = 8'h22; gold[32'h202] = 8'h33; gold[32'h203] = 8'h44;
    tick();
    run_model = 1'b1;
    @(negedge clk);
    chk("rst_grant", grant, 0); chk("rst_busy", busy, 0); chk("rst_rdata", rdata, 0);
    chk("rst_wr", mem_wr, 0);   chk("rst_a", mem_a, 0);
    tick();
    rst = 1'b0; rdy = 1'b1;

    // 4-byte store on ch1
    wait_idle();
    set_ch(1, 1'b1, 2'd2, 32'h100, 32'hAABBCCDD);
    for (int i = 1; i <= 4; i++) begin
      tick(); @(negedge clk);
      chk("wr_mem_wr", mem_wr, 1); chk("wr_a", mem_a, 32'h100 + i - 1);
      chk("wr_dout", mem_dout, wb[i-1]); chk("wr_early_done", done, 0);
    end
    tick(); @(negedge clk);
    chk("wr_done", done, 2'b10);

    // 4-byte load on ch0
    wait_idle();
    set_ch(0, 1'b0, 2'd2, 32'h200, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      tick(); @(negedge clk);
      chk("rd_a", mem_a, 32'h200 + i - 1); chk("rd_mem_wr", mem_wr, 0);
    end
    tick(); @(negedge clk);
    chk("rd_done", done, 2'b01); chk("rd_data", rdata, 32'h44332211);

    // load with three stall cycles after two bytes
    wait_idle();
    set_ch(0, 1'b0, 2'd2, 32'h200, 32'h0);
    for (int c = 1; c <= 8; c++) begin
      tick();
      rdy = (c >= 3 && c <= 5) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (c >= 3 && c <= 5) begin
        chk("stall_wr", mem_wr, 0); chk("stall_a", mem_a, 32'h202);
      end
      if (c < 8) chk("stall_early_done", done, 0);
      else begin
        chk("stall_done", done, 2'b01); chk("stall_data", rdata, 32'h44332211);
      end
    end

    // address wrap at the top of the space
    wait_idle();
    set_ch(0, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0);
    tick(); @(negedge clk); chk("wrap_a0", mem_a, 32'hFFFF_FFFF);
    tick(); @(negedge clk); chk("wrap_a1", mem_a, 32'h0000_0000);
    tick(); @(negedge clk);
    chk("wrap_done", done, 2'b01); chk("wrap_data", rdata, 32'h0000_3CC3);

    // abort a ch0 load after two bytes while ch1 waits
    wait_idle();
    set_ch(0, 1'b0, 2'd2, 32'h200, 32'h0);
    set_ch(1, 1'b1, 2'd0, 32'h300, 32'h5A);
    tick(); tick();
    tick(); abort[0] = 1'b1; req[0] = 1'b0;
    @(negedge clk); chk("abort_done", done, 0);
    tick(); abort = '0;
    @(negedge clk);
    chk("abort_busy", busy, 0); chk("abort_done_idle", done, 0);
    chk("abort_rdata", rdata, 32'h0000_3CC3);
    tick(); @(negedge clk); chk("abort_next_grant", grant, 2'b10);

    // reset in the middle of a store
    wait_idle();
    set_ch(1, 1'b1, 2'd2, 32'h180, 32'h01020304);
    tick(); tick();
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; req = '0;
    @(negedge clk);
    chk("mrst_grant", grant, 0); chk("mrst_busy", busy, 0); chk("mrst_wr", mem_wr, 0);
    chk("mrst_a", mem_a, 0); chk("mrst_dout", mem_dout, 0); chk("mrst_rdata", rdata, 0);
    chk("mrst_done", done, 0);

    // both channels requesting every IDLE: fixed vs round-robin
    wait_idle();
    set_ch(0, 1'b1, 2'd0, 32'h500, 32'h11);
    set_ch(1, 1'b1, 2'd0, 32'h501, 32'h22);
    for (int c = 1; c <= 7; c++) begin
      tick(); @(negedge clk);
      if (c == 1 || c == 4 || c == 7) begin
        chk("fixed_grant", grant, 2'b01);
        chk("rr_grant", grant_rr, (c == 4) ? 2'b10 : 2'b01);
      end
    end

    // randomized traffic
    wait_idle();
    for (int unsigned cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      sd = done; sg = grant;
      tick();
      for (int c = 0; c < NCH; c++) begin
        if (req[c] && (sd[c] || (sg[c] && abort[c] && !we[c]))) req[c] = 1'b0;
        else if (!req[c] && $urandom_range(0, 2) == 0) begin
          r = $urandom;
          a = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC | (r & 32'h3))
                                          : (32'h0000_0400 | (r & 32'h3F));
          set_ch(c, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom);
        end
      end
      for (int c = 0; c < NCH; c++) abort[c] = ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 4) != 0);
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
